// File: rtl/eth_xcvr_link_supervisor_if.sv
// Control/status bundle between the link supervisor, the transceiver/PHY
// wrappers and the housekeeping register block.
interface eth_xcvr_link_supervisor_if #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                          enable_in;
    logic                          clear_counts_in;
    logic [CHANNELS-1:0]           xcvr_gtpowergood_in;
    logic [CHANNELS-1:0]           xcvr_rx_reset_done_in;
    logic [CHANNELS-1:0]           phy_rx_block_lock_in;
    logic [CHANNELS-1:0]           phy_rx_high_ber_in;
    logic [CHANNELS-1:0]           xcvr_rx_reset_out;
    logic [CHANNELS-1:0]           link_up_out;
    logic [CHANNELS*CNT_WIDTH-1:0] relock_count_out;

    modport slave (
        input  enable_in,
        input  clear_counts_in,
        input  xcvr_gtpowergood_in,
        input  xcvr_rx_reset_done_in,
        input  phy_rx_block_lock_in,
        input  phy_rx_high_ber_in,
        output xcvr_rx_reset_out,
        output link_up_out,
        output relock_count_out
    );

    modport master (
        output enable_in,
        output clear_counts_in,
        output xcvr_gtpowergood_in,
        output xcvr_rx_reset_done_in,
        output phy_rx_block_lock_in,
        output phy_rx_high_ber_in,
        input  xcvr_rx_reset_out,
        input  link_up_out,
        input  relock_count_out
    );
endinterface

// File: rtl/eth_xcvr_link_supervisor.sv
// Multi-channel 10G transceiver link supervisor: input sync, per-channel lock FSM,
// arbitrated RX reset pulses, relock counters. Define ETH_LINK_SUP_DEBOUNCE_EN for lock-loss debounce.
module eth_xcvr_link_supervisor #(
    parameter int unsigned CHANNELS           = 4,
    parameter int unsigned LOCK_TIMEOUT       = 1000000,
    parameter int unsigned RESET_PULSE_CYCLES = 16,
    parameter int unsigned HOLDOFF_CYCLES     = 256,
    parameter int unsigned CNT_WIDTH          = 16,
    parameter int unsigned DEBOUNCE_CYCLES    = 8
) (
    input  logic                      xcvr_ctrl_clk,
    input  logic                      xcvr_ctrl_rst,
    eth_xcvr_link_supervisor_if.slave sup
);

    localparam int unsigned TMAX_A = (LOCK_TIMEOUT > RESET_PULSE_CYCLES) ? LOCK_TIMEOUT : RESET_PULSE_CYCLES;
    localparam int unsigned TMAX   = (TMAX_A > HOLDOFF_CYCLES) ? TMAX_A : HOLDOFF_CYCLES;
    localparam int unsigned TW     = $clog2(TMAX);
    localparam int unsigned NIN    = 4 * CHANNELS;

    if (CHANNELS < 1 || CHANNELS > 16 || LOCK_TIMEOUT < 2 || RESET_PULSE_CYCLES < 1 ||
        HOLDOFF_CYCLES < 1 || CNT_WIDTH < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("eth_xcvr_link_supervisor: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DONE,
        ST_WAIT_LOCK,
        ST_UP,
        ST_RESET_REQ,
        ST_RESET,
        ST_HOLDOFF
    } state_t;

    logic [NIN-1:0]       async_in;
    logic [NIN-1:0]       sync1_q, sync1_d;
    logic [NIN-1:0]       sync2_q, sync2_d;
    logic [CHANNELS-1:0]  pg, done, lock, ber;

    state_t               state_q [CHANNELS];
    state_t               state_d [CHANNELS];
    logic [TW-1:0]        timer_q [CHANNELS];
    logic [TW-1:0]        timer_d [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_q   [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_d   [CHANNELS];
    logic [CHANNELS-1:0]  rst_out_q, rst_out_d;
    logic [CHANNELS-1:0]  link_up_q, link_up_d;
    logic [CHANNELS-1:0]  req, grant, loss;
    logic                 busy, granted;

`ifdef ETH_LINK_SUP_DEBOUNCE_EN
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DEB_W-1:0]     deb_q [CHANNELS];
    logic [DEB_W-1:0]     deb_d [CHANNELS];
`endif

    assign async_in = {sup.phy_rx_high_ber_in, sup.phy_rx_block_lock_in,
                       sup.xcvr_rx_reset_done_in, sup.xcvr_gtpowergood_in};
    assign pg   = sync2_q[0*CHANNELS +: CHANNELS];
    assign done = sync2_q[1*CHANNELS +: CHANNELS];
    assign lock = sync2_q[2*CHANNELS +: CHANNELS];
    assign ber  = sync2_q[3*CHANNELS +: CHANNELS];

    always_comb begin
        sync1_d   = async_in;
        sync2_d   = sync1_q;
        state_d   = state_q;
        timer_d   = timer_q;
        cnt_d     = cnt_q;
        rst_out_d = '0;
        link_up_d = '0;
        req       = '0;
        grant     = '0;
        loss      = '0;
        busy      = 1'b0;
        granted   = 1'b0;
`ifdef ETH_LINK_SUP_DEBOUNCE_EN
        deb_d     = deb_q;
`endif

        for (int unsigned i = 0; i < CHANNELS; i++) begin
            req[i]  = (state_q[i] == ST_RESET_REQ) && sup.enable_in && pg[i];
            busy    = busy | (state_q[i] == ST_RESET);
            loss[i] = !lock[i] || ber[i] || !done[i];
        end

        // Single pulse slot: grant only while nobody is pulsing, lowest index first.
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (!busy && req[i] && !granted) begin
                grant[i] = 1'b1;
                granted  = 1'b1;
            end
        end

        for (int unsigned i = 0; i < CHANNELS; i++) begin
            case (state_q[i])
                ST_IDLE: begin
                    if (sup.enable_in && pg[i]) state_d[i] = ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (done[i]) begin
                        state_d[i] = ST_WAIT_LOCK;
                        timer_d[i] = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock[i] && !ber[i]) begin
                        state_d[i] = ST_UP;
                    end else if (timer_q[i] == TW'(LOCK_TIMEOUT - 1)) begin
                        state_d[i] = ST_RESET_REQ;
                    end else begin
                        timer_d[i] = timer_q[i] + 1'b1;
                    end
                end
                ST_UP: begin
`ifdef ETH_LINK_SUP_DEBOUNCE_EN
                    if (loss[i]) begin
                        if (deb_q[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                            state_d[i] = ST_RESET_REQ;
                            deb_d[i]   = '0;
                        end else begin
                            deb_d[i] = deb_q[i] + 1'b1;
                        end
                    end else begin
                        deb_d[i] = '0;
                    end
`else
                    if (loss[i]) state_d[i] = ST_RESET_REQ;
`endif
                end
                ST_RESET_REQ: begin
                    if (grant[i]) begin
                        state_d[i] = ST_RESET;
                        timer_d[i] = '0;
                    end
                end
                ST_RESET: begin
                    if (timer_q[i] == TW'(RESET_PULSE_CYCLES - 1)) begin
                        state_d[i] = ST_HOLDOFF;
                        timer_d[i] = '0;
                    end else begin
                        timer_d[i] = timer_q[i] + 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (timer_q[i] == TW'(HOLDOFF_CYCLES - 1)) begin
                        state_d[i] = ST_WAIT_DONE;
                        timer_d[i] = '0;
                    end else begin
                        timer_d[i] = timer_q[i] + 1'b1;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase

            if (!sup.enable_in || !pg[i]) begin
                state_d[i] = ST_IDLE;
                timer_d[i] = '0;
            end
`ifdef ETH_LINK_SUP_DEBOUNCE_EN
            if (state_d[i] != ST_UP) deb_d[i] = '0;
`endif

            if (sup.clear_counts_in) begin
                cnt_d[i] = '0;
            end else if (grant[i] && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end

            rst_out_d[i] = (state_d[i] == ST_RESET);
            link_up_d[i] = (state_d[i] == ST_UP);
        end
    end

    always_ff @(posedge xcvr_ctrl_clk or posedge xcvr_ctrl_rst) begin
        if (xcvr_ctrl_rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            rst_out_q <= '0;
            link_up_q <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_IDLE;
                timer_q[i] <= '0;
                cnt_q[i]   <= '0;
`ifdef ETH_LINK_SUP_DEBOUNCE_EN
                deb_q[i]   <= '0;
`endif
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            rst_out_q <= rst_out_d;
            link_up_q <= link_up_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef ETH_LINK_SUP_DEBOUNCE_EN
                deb_q[i]   <= deb_d[i];
`endif
            end
        end
    end

    assign sup.xcvr_rx_reset_out = rst_out_q;
    assign sup.link_up_out       = link_up_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt_out
        assign sup.relock_count_out[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
    end

endmodule

// File: tb/tb_eth_xcvr_link_supervisor.sv
// Directed self-checking bench for eth_xcvr_link_supervisor (2 channels, short timers).
// Debounce vectors are compiled when ETH_LINK_SUP_DEBOUNCE_EN is defined.
module tb_eth_xcvr_link_supervisor;

    localparam int unsigned CH = 2;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    int w_rise [2];
    int w_hi   [2];
    int w_first[2];
    int w_last [2];
    int w_both;
    int w_up0_low;

    eth_xcvr_link_supervisor_if #(.CHANNELS(CH), .CNT_WIDTH(CW)) sup_if ();

    eth_xcvr_link_supervisor #(
        .CHANNELS          (CH),
        .LOCK_TIMEOUT      (100),
        .RESET_PULSE_CYCLES(4),
        .HOLDOFF_CYCLES    (8),
        .CNT_WIDTH         (CW),
        .DEBOUNCE_CYCLES   (8)
    ) dut (
        .xcvr_ctrl_clk(clk),
        .xcvr_ctrl_rst(rst),
        .sup          (sup_if)
    );

    always #5 clk = ~clk;

    logic [1:0]    rst_o, up_o;
    logic [CW-1:0] cnt0, cnt1;
    assign rst_o = sup_if.xcvr_rx_reset_out;
    assign up_o  = sup_if.link_up_out;
    assign cnt0  = sup_if.relock_count_out[CW-1:0];
    assign cnt1  = sup_if.relock_count_out[2*CW-1:CW];

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rst0(input logic level, input int limit, input string tag);
        int n = 0;
        while (rst_o[0] != level && n < limit) begin
            tick(1);
            n++;
        end
        check_eq(tag, int'(rst_o[0]), int'(level));
    endtask

    task automatic watch(input int n);
        logic [1:0] prev;
        prev = rst_o;
        for (int k = 0; k < 2; k++) begin
            w_rise[k] = 0; w_hi[k] = 0; w_first[k] = -1; w_last[k] = -1;
        end
        w_both = 0;
        w_up0_low = 0;
        for (int c = 0; c < n; c++) begin
            tick(1);
            for (int k = 0; k < 2; k++) begin
                if (rst_o[k]) begin
                    w_hi[k]++;
                    w_last[k] = c;
                    if (!prev[k]) begin
                        w_rise[k]++;
                        if (w_first[k] < 0) w_first[k] = c;
                    end
                end
            end
            if (&rst_o) w_both++;
            if (!up_o[0]) w_up0_low++;
            prev = rst_o;
        end
    endtask

    initial begin
        int n;
        int lows;
        int highs;
        sup_if.enable_in             = 1'b0;
        sup_if.clear_counts_in       = 1'b0;
        sup_if.xcvr_gtpowergood_in   = '0;
        sup_if.xcvr_rx_reset_done_in = '0;
        sup_if.phy_rx_block_lock_in  = '0;
        sup_if.phy_rx_high_ber_in    = '0;
        tick(3);
        check_eq("reset_rst_out", int'(rst_o), 0);
        check_eq("reset_link_up", int'(up_o), 0);
        check_eq("reset_counts", int'(sup_if.relock_count_out), 0);
        rst = 1'b0;

`ifdef ETH_LINK_SUP_DEBOUNCE_EN
        sup_if.enable_in             = 1'b1;
        sup_if.xcvr_gtpowergood_in   = 2'b11;
        sup_if.xcvr_rx_reset_done_in = 2'b11;
        sup_if.phy_rx_block_lock_in  = 2'b11;
        tick(10);
        check_eq("deb_bringup", int'(up_o), 3);

        // 7-cycle glitch: absorbed by debounce
        sup_if.phy_rx_block_lock_in = 2'b10;
        watch(7);
        n = w_rise[0];
        lows = w_up0_low;
        sup_if.phy_rx_block_lock_in = 2'b11;
        watch(30);
        check_eq("deb7_no_pulse", n + w_rise[0], 0);
        check_eq("deb7_link_held", lows + w_up0_low, 0);
        check_eq("deb7_count", int'(cnt0), 0);

        // 8-cycle glitch: exactly one relock
        sup_if.phy_rx_block_lock_in = 2'b10;
        watch(8);
        n = w_rise[0];
        sup_if.phy_rx_block_lock_in = 2'b11;
        watch(60);
        check_eq("deb8_one_pulse", n + w_rise[0], 1);
        check_eq("deb8_width", w_hi[0], 4);
        check_eq("deb8_count", int'(cnt0), 1);
        check_eq("deb8_relinked", int'(up_o), 3);
`else
        // Enable low keeps everything idle
        sup_if.xcvr_gtpowergood_in   = 2'b11;
        sup_if.xcvr_rx_reset_done_in = 2'b11;
        tick(10);
        check_eq("idle_when_disabled", int'(up_o), 0);

        // Normal bring-up
        sup_if.enable_in = 1'b1;
        tick(8);
        check_eq("no_up_without_lock", int'(up_o), 0);
        sup_if.phy_rx_block_lock_in = 2'b11;
        tick(2);
        check_eq("up_not_before_sync", int'(up_o), 0);
        n = 2;
        while (up_o != 2'b11 && n < 8) begin
            tick(1);
            n++;
        end
        check_eq("bringup_link_up", int'(up_o), 3);
        check_eq("bringup_within_4", (n <= 4) ? 1 : 0, 1);
        check_eq("bringup_no_reset", int'(rst_o), 0);
        check_eq("bringup_counts", int'(sup_if.relock_count_out), 0);

        // Simultaneous loss on both channels
        sup_if.phy_rx_block_lock_in = 2'b00;
        watch(60);
        check_eq("sim_ch0_pulses", w_rise[0], 1);
        check_eq("sim_ch1_pulses", w_rise[1], 1);
        check_eq("sim_ch0_width", w_hi[0], 4);
        check_eq("sim_ch1_width", w_hi[1], 4);
        check_eq("sim_no_overlap", w_both, 0);
        check_eq("sim_ch0_first", (w_first[1] > w_last[0]) ? 1 : 0, 1);
        check_eq("sim_cnt0", int'(cnt0), 1);
        check_eq("sim_cnt1", int'(cnt1), 1);
        check_eq("sim_link_down", int'(up_o), 0);
        sup_if.phy_rx_block_lock_in = 2'b11;
        tick(10);
        check_eq("sim_relinked", int'(up_o), 3);

        // Disable during the second cycle of a ch0 pulse
        sup_if.phy_rx_block_lock_in = 2'b10;
        wait_rst0(1'b1, 20, "dis_pulse_start");
        tick(1);
        check_eq("dis_pulse_cycle2", int'(rst_o), 1);
        sup_if.enable_in = 1'b0;
        tick(1);
        check_eq("dis_rst_dropped", int'(rst_o), 0);
        check_eq("dis_link_dropped", int'(up_o), 0);
        check_eq("dis_cnt0_kept", int'(cnt0), 2);
        check_eq("dis_cnt1_kept", int'(cnt1), 1);

        // Clear collides with a grant
        sup_if.phy_rx_block_lock_in = 2'b11;
        sup_if.enable_in = 1'b1;
        tick(12);
        check_eq("clr_relinked", int'(up_o), 3);
        sup_if.phy_rx_block_lock_in = 2'b10;
        tick(3);
        check_eq("clr_pre_rst", int'(rst_o), 0);
        check_eq("clr_pre_cnt0", int'(cnt0), 2);
        sup_if.clear_counts_in = 1'b1;
        tick(1);
        sup_if.clear_counts_in = 1'b0;
        check_eq("clr_granted", int'(rst_o), 1);
        check_eq("clr_cnt0", int'(cnt0), 0);
        check_eq("clr_cnt1", int'(cnt1), 0);

        // Lock timeout on ch0: holdoff + wait_done + timeout + request, then 4-cycle pulse
        wait_rst0(1'b0, 20, "to_pulse_end");
        lows = 1;
        while (lows < 300) begin
            tick(1);
            if (rst_o[0]) break;
            lows++;
        end
        check_eq("to_low_cycles", lows, 110);
        highs = 1;
        while (highs < 20) begin
            tick(1);
            if (!rst_o[0]) break;
            highs++;
        end
        check_eq("to_pulse_width", highs, 4);
        check_eq("to_cnt0", int'(cnt0), 1);

        // Repeated timeouts saturate the counter
        for (int p = 2; p <= 15; p++) begin
            wait_rst0(1'b1, 200, "sat_pulse");
            wait_rst0(1'b0, 20, "sat_pulse_end");
        end
        check_eq("sat_cnt0_15", int'(cnt0), 15);
        check_eq("sat_cnt1_idle", int'(cnt1), 0);
        check_eq("sat_ch1_up", int'(up_o), 2);
        wait_rst0(1'b1, 200, "sat_extra_pulse");
        check_eq("sat_cnt0_held", int'(cnt0), 15);

        // Asynchronous reset in the middle of a pulse
        #2 rst = 1'b1;
        #1;
        check_eq("arst_rst_out", int'(rst_o), 0);
        check_eq("arst_link_up", int'(up_o), 0);
        check_eq("arst_counts", int'(sup_if.relock_count_out), 0);
        tick(1);
        rst = 1'b0;
`endif
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
